// File: rtl/pc_gen.sv
// pc_gen: RV32I program counter and fetch-request generator with branch/jump redirect
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    decode hazard hold; blocks new fetches
//   br_taken, br_target      branch-unit redirect request and target
//   jump, jump_target        JAL/JALR redirect request and target (wins over branch)
//   fetch_valid, fetch_ready fetch request handshake with instruction memory
//   fetch_addr               current request address
//   pc_out, pc_plus4         last accepted fetch address and its successor
//   flush                    one-cycle wrong-path kill after a redirect
//   misalign_exc             one-cycle misaligned-target pulse
// Build option PC_GEN_MISALIGN_EN: targets with bit 1 set raise misalign_exc and
// are dropped; without it the target is silently word-aligned.
module pc_gen #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_addr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        flush,
    output logic        misalign_exc
);
    typedef enum logic [1:0] {BOOT, RUN, STALL, REDIR} state_t;
    state_t      state, nxt_state;
    logic [31:0] pend_addr, nxt_pend, nxt_addr, raw_tgt, target;
    logic        req, mis, redirect, accept;
    assign req     = jump | br_taken;
    assign raw_tgt = jump ? jump_target : br_target;
`ifdef PC_GEN_MISALIGN_EN
    assign target = raw_tgt & ~32'h1;
    assign mis    = req & raw_tgt[1];
`else
    assign target = raw_tgt & ~32'h3;
    assign mis    = 1'b0;
`endif
    // a misaligned request is dropped entirely: no redirect, no flush
    assign redirect    = req & ~mis;
    // REDIR keeps the old request up so the handshake is never withdrawn
    assign fetch_valid = (state == RUN) | (state == REDIR);
    assign accept      = fetch_valid & fetch_ready;
    assign pc_plus4    = pc_out + 32'd4;
    always_comb begin
        nxt_state = state;
        nxt_addr  = fetch_addr;
        nxt_pend  = pend_addr;
        case (state)
            BOOT: begin
                nxt_state = RUN;
                nxt_addr  = redirect ? target : fetch_addr;
            end
            RUN: begin
                if (redirect && fetch_ready) begin
                    nxt_addr = target;
                end else if (redirect) begin
                    nxt_pend  = target;
                    nxt_state = REDIR;
                end else if (accept) begin
                    nxt_addr  = fetch_addr + 32'd4;
                    nxt_state = stall ? STALL : RUN;
                end
            end
            STALL: begin
                nxt_addr  = redirect ? target : fetch_addr;
                nxt_state = (redirect || !stall) ? RUN : STALL;
            end
            default: begin
                // a redirect arriving in the same cycle as the accept is the newest target
                nxt_pend = redirect ? target : pend_addr;
                if (fetch_ready) begin
                    nxt_addr  = nxt_pend;
                    nxt_state = RUN;
                end
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            fetch_addr   <= RESET_PC;
            pc_out       <= RESET_PC;
            pend_addr    <= 32'h0;
            flush        <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            state        <= nxt_state;
            fetch_addr   <= nxt_addr;
            pend_addr    <= nxt_pend;
            pc_out       <= accept ? fetch_addr : pc_out;
            flush        <= redirect;
            misalign_exc <= mis;
        end
    end
endmodule

// File: doc/pc_gen.md
# pc_gen

Program-counter and fetch-request generator for the RV32I core; it sits directly downstream of the branch unit and consumes its taken/not-taken result. It holds the fetch address, issues valid/ready fetch requests to instruction memory, advances by 4 on each accepted fetch, and redirects to branch or jump targets. On a redirect it pulses a one-cycle flush that kills the wrong-path instruction.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  system clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard hold from decode; no new fetch is issued while high
- br_taken  in  1  branch-unit result (`res`); already qualified by the branch enable
- br_target  in  32  branch target, valid when br_taken=1
- jump  in  1  JAL/JALR redirect request
- jump_target  in  32  jump target, valid when jump=1
- fetch_valid  out  1  fetch request valid
- fetch_ready  in  1  instruction memory accepts the request this cycle
- fetch_addr  out  32  request address; held stable while fetch_valid=1 and fetch_ready=0
- pc_out  out  32  address of the most recently accepted fetch
- pc_plus4  out  32  pc_out+4, combinational, modulo 2^32
- flush  out  1  one-cycle kill of the wrong-path instruction
- misalign_exc  out  1  one-cycle instruction-address-misaligned pulse

## Operation
- redirect = jump | br_taken. If both are high, jump wins and the target is jump_target.
- target[0] is forced to 0 (JALR rule).
- Accept = fetch_valid & fetch_ready.
- States and transitions:
  - BOOT: fetch_valid=0. Always goes to RUN on the next cycle.
  - RUN: fetch_valid=1.
    - redirect & ready: fetch_addr<=target; stay in RUN.
    - redirect & !ready: pend_addr<=target; go to REDIR.
    - !redirect & accept & stall: fetch_addr+=4; go to STALL.
    - !redirect & accept & !stall: fetch_addr+=4; stay in RUN.
    - Any other case: hold.
  - STALL: fetch_valid=0.
    - redirect: fetch_addr<=target; go to RUN.
    - !stall: go to RUN.
  - REDIR: fetch_valid=1 with the old fetch_addr, so the handshake is never withdrawn.
    - A new redirect overwrites pend_addr.
    - On accept: fetch_addr<=pend_addr; go to RUN.
- pc_out<=fetch_addr on every accept, including the accept that completes a redirect.
- A redirect takes priority over stall in every state.
- Address arithmetic is 32-bit unsigned and wraps: 0xFFFF_FFFC+4 gives 0x0000_0000.

## Timing
- Reset values:
  - state=BOOT
  - fetch_valid=0
  - fetch_addr=RESET_PC
  - pc_out=RESET_PC
  - pc_plus4=RESET_PC+4
  - flush=0
  - misalign_exc=0
  - pend_addr=0
- rst has priority over every input; reset mid-REDIR discards pend_addr.
- The first request appears in the second cycle after rst deasserts (BOOT lasts exactly one cycle).
- Redirect seen at edge N:
  - flush=1 during cycle N+1 only.
  - The target is on fetch_addr in cycle N+1 if fetch_ready was high at edge N (RUN) or the block was in STALL. Otherwise it appears the cycle after the pending request is accepted.
- Redirects on consecutive cycles produce flush on consecutive cycles; the last target wins.
- fetch_valid never drops between assertion and accept, except through rst.
- Steady state with fetch_ready=1 and no stall: one accept per cycle.

## Configuration
- PC_GEN_MISALIGN_EN defined:
  - A redirect with target[1]=1 is suppressed: fetch_addr and state are unchanged, no flush.
  - misalign_exc=1 for the cycle after the redirect is seen.
- PC_GEN_MISALIGN_EN undefined:
  - target[1:0] is forced to 2'b00.
  - misalign_exc is tied to 0.

## Test plan
- Reset: RESET_PC=0x100, rst for 2 cycles, fetch_ready=1 -> one BOOT cycle with fetch_valid=0, then accepted fetch_addr 0x100, 0x104, 0x108 on successive cycles; pc_out trails by one cycle.
- Backpressure: fetch_ready=0 for 3 cycles at 0x104 -> fetch_valid stays 1 and fetch_addr stays 0x104; after accept, next fetch_addr=0x108.
- Branch: br_taken=1 with br_target=0x200 while ready=1 -> flush=1 for exactly one cycle, next fetch_addr=0x200, then 0x204. With jump=1 to 0x300 in the same cycle -> 0x300 wins.
- Redirect under backpressure: br_taken=1 with target 0x40 while ready=0 -> REDIR; a later jump to 0x80 before accept -> after accept, fetch_addr=0x80.
- Stall: stall=1 at accept of 0x10 -> fetch_valid=0 until stall drops, then 0x14. A redirect to 0x500 during the stall -> RUN with 0x500 and one flush.
- Edge cases: fetch_addr 0xFFFF_FFFC accepted -> next fetch_addr 0x0. With PC_GEN_MISALIGN_EN, br_target=0x202 -> misalign_exc pulse, no redirect, no flush.
